// File: rtl/reg_file.sv
// Architectural register file with ROB rename tags; operand reads resolve to a value or a pending tag.
// Reads are combinational; writes land on the next edge; rdy_in low freezes state. `REG_BYPASS_EN forwards the commit bus.
module reg_file #(
   parameter int ROB_BIT = 3
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               issue_valid,
   input  logic [4:0]         issue_rd,
   input  logic [ROB_BIT-1:0] issue_rob_entry,
   input  logic               commit_valid,
   input  logic [4:0]         commit_rd,
   input  logic [ROB_BIT-1:0] commit_rob_entry,
   input  logic [31:0]        commit_value,
   input  logic               clear_up,
   input  logic [4:0]         rs1_id,
   input  logic [4:0]         rs2_id,
   output logic               rs1_ready,
   output logic               rs2_ready,
   output logic [31:0]        rs1_value,
   output logic [31:0]        rs2_value,
   output logic [ROB_BIT-1:0] rs1_rob_entry,
   output logic [ROB_BIT-1:0] rs2_rob_entry,
   output logic [ROB_BIT-1:0] get_rob_entry1,
   output logic [ROB_BIT-1:0] get_rob_entry2,
   input  logic               ready1,
   input  logic               ready2,
   input  logic [31:0]        value1,
   input  logic [31:0]        value2
);

   typedef struct packed {
      logic               ready;
      logic [31:0]        value;
      logic [ROB_BIT-1:0] entry;
   } rd_res_t;

   logic [31:0]        val_q [32];
   logic [ROB_BIT-1:0] tag_q [32];
   logic [31:0]        busy_q;

   // Later assignments win: a flush overrides the commit's busy clear, an issue overrides it too.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy_q <= '0;
         for (int i = 0; i < 32; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else if (rdy_in) begin
         if (commit_valid && commit_rd != 5'd0) begin
            val_q[commit_rd] <= commit_value;
            if (busy_q[commit_rd] && tag_q[commit_rd] == commit_rob_entry)
               busy_q[commit_rd] <= 1'b0;
         end
         if (clear_up) begin
            busy_q <= '0;
         end else if (issue_valid && issue_rd != 5'd0) begin
            busy_q[issue_rd] <= 1'b1;
            tag_q[issue_rd]  <= issue_rob_entry;
         end
      end
   end

   function automatic rd_res_t resolve(input logic [4:0] id, input logic lk_ready,
                                       input logic [31:0] lk_value);
      rd_res_t r;
      r = '{ready: 1'b1, value: val_q[id], entry: '0};
      if (id == 5'd0) begin
         r.value = '0;
      end else if (busy_q[id]) begin
`ifdef REG_BYPASS_EN
         if (commit_valid && commit_rd == id && commit_rob_entry == tag_q[id])
            r.value = commit_value;
         else
`endif
         if (lk_ready)
            r.value = lk_value;
         else
            r = '{ready: 1'b0, value: '0, entry: tag_q[id]};
      end
      return r;
   endfunction

   rd_res_t res1, res2;

   always_comb begin
      res1 = resolve(rs1_id, ready1, value1);
      res2 = resolve(rs2_id, ready2, value2);
   end

   assign rs1_ready      = res1.ready;
   assign rs1_value      = res1.value;
   assign rs1_rob_entry  = res1.entry;
   assign rs2_ready      = res2.ready;
   assign rs2_value      = res2.value;
   assign rs2_rob_entry  = res2.entry;
   assign get_rob_entry1 = tag_q[rs1_id];
   assign get_rob_entry2 = tag_q[rs2_id];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed sequences, a read-vector table and a randomized run against an array model.
module tb_reg_file;
   localparam int RB = 3;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in;
   logic          issue_valid, commit_valid, clear_up;
   logic [4:0]    issue_rd, commit_rd, rs1_id, rs2_id;
   logic [RB-1:0] issue_rob_entry, commit_rob_entry;
   logic [31:0]   commit_value, value1, value2;
   logic          ready1, ready2;
   logic          rs1_ready, rs2_ready;
   logic [31:0]   rs1_value, rs2_value;
   logic [RB-1:0] rs1_rob_entry, rs2_rob_entry, get_rob_entry1, get_rob_entry2;

   int n_checks = 0;
   int n_errors = 0;

   reg_file #(.ROB_BIT(RB)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_entry(issue_rob_entry),
      .commit_valid(commit_valid), .commit_rd(commit_rd),
      .commit_rob_entry(commit_rob_entry), .commit_value(commit_value),
      .clear_up(clear_up), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
      .rs1_value(rs1_value), .rs2_value(rs2_value),
      .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry),
      .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
      .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2)
   );

   always #5 clk_in = ~clk_in;

   // Reference state: what each architectural register holds and who owns it.
   logic [31:0]   m_val  [32];
   bit            m_busy [32];
   logic [RB-1:0] m_tag  [32];

   task automatic model_step();
      if (rst_in) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
         end
      end else if (rdy_in) begin
         if (commit_valid && commit_rd != 0) begin
            m_val[commit_rd] = commit_value;
            if (m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_entry)
               m_busy[commit_rd] = 0;
         end
         if (clear_up) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
         end else if (issue_valid && issue_rd != 0) begin
            m_busy[issue_rd] = 1;
            m_tag[issue_rd]  = issue_rob_entry;
         end
      end
   endtask

   task automatic model_read(input logic [4:0] id, input logic lk_r, input logic [31:0] lk_v,
                             output logic er, output logic [31:0] ev, output logic [RB-1:0] ee);
      er = 1; ev = m_val[id]; ee = 0;
      if (id == 0) ev = 0;
      else if (m_busy[id]) begin
`ifdef REG_BYPASS_EN
         if (commit_valid && commit_rd == id && commit_rob_entry == m_tag[id]) begin
            ev = commit_value;
         end else
`endif
         if (lk_r) ev = lk_v;
         else begin er = 0; ev = 0; ee = m_tag[id]; end
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic er, input logic [31:0] ev, input logic [RB-1:0] ee);
      check({nm, ".rdy1"}, 32'(rs1_ready), 32'(er));
      check({nm, ".val1"}, rs1_value, ev);
      check({nm, ".ent1"}, 32'(rs1_rob_entry), 32'(ee));
   endtask

   task automatic idle();
      rst_in = 0; rdy_in = 1; issue_valid = 0; commit_valid = 0; clear_up = 0;
      issue_rd = 0; issue_rob_entry = 0; commit_rd = 0; commit_rob_entry = 0; commit_value = 0;
      ready1 = 0; ready2 = 0; value1 = 0; value2 = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_in);
      #1;
      idle();
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic [RB-1:0] e);
      issue_valid = 1; issue_rd = rd; issue_rob_entry = e; tick();
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [RB-1:0] e, input logic [31:0] v);
      commit_valid = 1; commit_rd = rd; commit_rob_entry = e; commit_value = v; tick();
   endtask

   typedef struct {
      logic [4:0]    id;
      logic          lk_r;
      logic [31:0]   lk_v;
      logic          er;
      logic [31:0]   ev;
      logic [RB-1:0] ee;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic er, er2;
      logic [31:0] ev, ev2;
      logic [RB-1:0] ee, ee2;

      idle();
      rs1_id = 0; rs2_id = 0;
      rst_in = 1; tick();

      // Reset state and x0 hardwiring
      rs1_id = 5; rs2_id = 5; #1;
      chk1("rst_x5", 1, 0, 0);
      check("rst_x5.rdy2", 32'(rs2_ready), 1);
      check("rst_x5.val2", rs2_value, 0);
      do_commit(0, 0, 32'h1234);
      rs1_id = 0; #1;
      chk1("x0_commit", 1, 0, 0);

      // Rename then ROB lookup
      do_issue(3, 2);
      rs1_id = 3; #1;
      chk1("x3_pend", 0, 0, 2);
      check("x3_get1", 32'(get_rob_entry1), 2);
      ready1 = 1; value1 = 32'hDEAD; #1;
      chk1("x3_lookup", 1, 32'hDEAD, 0);

      // Older commit must not release a younger rename
      do_issue(3, 5);
      do_commit(3, 2, 7);
      rs1_id = 3; #1;
      chk1("x3_young", 0, 0, 5);
      do_commit(3, 5, 9);
      rs1_id = 3; #1;
      chk1("x3_done", 1, 9, 0);

      // Same-cycle issue and commit on one register
      issue_valid = 1; issue_rd = 4; issue_rob_entry = 6;
      commit_valid = 1; commit_rd = 4; commit_rob_entry = 1; commit_value = 32'h55;
      tick();
      rs1_id = 4; #1;
      chk1("x4_issue_wins", 0, 0, 6);
      do_commit(4, 6, 32'h66);
      rs1_id = 4; #1;
      chk1("x4_done", 1, 32'h66, 0);

      // Flush with same-cycle issue (dropped) and commit (kept)
      do_commit(1, 0, 32'h11);
      do_commit(2, 0, 32'h22);
      do_commit(7, 0, 32'h77);
      do_issue(1, 1);
      do_issue(2, 2);
      do_issue(7, 7);
      clear_up = 1;
      issue_valid = 1; issue_rd = 8; issue_rob_entry = 3;
      commit_valid = 1; commit_rd = 9; commit_rob_entry = 0; commit_value = 32'hAB;
      tick();

      vecs[0] = '{id: 1, lk_r: 0, lk_v: 0,         er: 1, ev: 32'h11, ee: 0};
      vecs[1] = '{id: 2, lk_r: 0, lk_v: 0,         er: 1, ev: 32'h22, ee: 0};
      vecs[2] = '{id: 7, lk_r: 0, lk_v: 0,         er: 1, ev: 32'h77, ee: 0};
      vecs[3] = '{id: 8, lk_r: 0, lk_v: 0,         er: 1, ev: 0,      ee: 0};
      vecs[4] = '{id: 9, lk_r: 0, lk_v: 0,         er: 1, ev: 32'hAB, ee: 0};
      vecs[5] = '{id: 1, lk_r: 1, lk_v: 32'hBAD,   er: 1, ev: 32'h11, ee: 0};
      vecs[6] = '{id: 0, lk_r: 1, lk_v: 32'hBAD,   er: 1, ev: 0,      ee: 0};
      vecs[7] = '{id: 3, lk_r: 1, lk_v: 32'hF00,   er: 1, ev: 9,      ee: 0};
      for (int i = 0; i < 8; i++) begin
         rs1_id = vecs[i].id; ready1 = vecs[i].lk_r; value1 = vecs[i].lk_v;
         rs2_id = vecs[i].id; ready2 = vecs[i].lk_r; value2 = vecs[i].lk_v;
         #1;
         chk1($sformatf("flush_vec%0d", i), vecs[i].er, vecs[i].ev, vecs[i].ee);
         check($sformatf("flush_vec%0d.val2", i), rs2_value, vecs[i].ev);
      end

      // rdy_in low freezes state
      rdy_in = 0;
      issue_valid = 1; issue_rd = 5; issue_rob_entry = 3;
      commit_valid = 1; commit_rd = 1; commit_rob_entry = 0; commit_value = 32'h99;
      tick();
      rs1_id = 5; rs2_id = 1; #1;
      chk1("stall_x5", 1, 0, 0);
      check("stall_x1.val2", rs2_value, 32'h11);

      // Commit-cycle read: forwarded only with the bypass
      do_issue(3, 4);
      commit_valid = 1; commit_rd = 3; commit_rob_entry = 4; commit_value = 32'h77;
      rs1_id = 3; ready1 = 0; #1;
`ifdef REG_BYPASS_EN
      chk1("bypass", 1, 32'h77, 0);
`else
      chk1("no_bypass", 0, 0, 4);
`endif
      tick();
      rs1_id = 3; #1;
      chk1("x3_after_commit", 1, 32'h77, 0);

      // Reset mid-operation
      do_issue(6, 2);
      rst_in = 1; tick();
      rs1_id = 3; rs2_id = 6; #1;
      chk1("rst_mid_x3", 1, 0, 0);
      check("rst_mid_x6.rdy2", 32'(rs2_ready), 1);

      // Randomized run against the model
      for (int c = 0; c < 600; c++) begin
         rst_in       = ($urandom_range(0, 199) == 0);
         rdy_in       = ($urandom_range(0, 99) < 85);
         clear_up     = ($urandom_range(0, 99) < 5);
         issue_valid  = $urandom_range(0, 1);
         issue_rd     = 5'($urandom_range(0, 7));
         issue_rob_entry = RB'($urandom);
         commit_valid = $urandom_range(0, 1);
         commit_rd    = 5'($urandom_range(0, 7));
         commit_rob_entry = $urandom_range(0, 1) ? m_tag[commit_rd] : RB'($urandom);
         commit_value = $urandom;
         rs1_id = 5'($urandom_range(0, 7)); rs2_id = 5'($urandom_range(0, 7));
         ready1 = $urandom_range(0, 1); ready2 = $urandom_range(0, 1);
         value1 = $urandom; value2 = $urandom;
         #1;
         model_read(rs1_id, ready1, value1, er, ev, ee);
         model_read(rs2_id, ready2, value2, er2, ev2, ee2);
         check("rnd.rdy1", 32'(rs1_ready), 32'(er));
         check("rnd.val1", rs1_value, ev);
         check("rnd.ent1", 32'(rs1_rob_entry), 32'(ee));
         check("rnd.get1", 32'(get_rob_entry1), 32'(m_tag[rs1_id]));
         check("rnd.rdy2", 32'(rs2_ready), 32'(er2));
         check("rnd.val2", rs2_value, ev2);
         check("rnd.ent2", 32'(rs2_rob_entry), 32'(ee2));
         check("rnd.get2", 32'(get_rob_entry2), 32'(m_tag[rs2_id]));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags for the Tomasulo core. It accepts issue (rename) and commit writes from the reorder buffer and serves two decoder operand reads per cycle. Each read resolves to one of two results: a ready 32-bit value, or a pending ROB entry. For a renamed register it queries the ROB ready/value lookup port. It drops all renames on a mispredict flush.

## Interface
- `ROB_BIT`, default 3 (`` `ROB_BIT `` from Const.v): ROB index width.
- `clk_in` in 1: system clock.
- `rst_in` in 1: synchronous active-high reset.
- `rdy_in` in 1: when low, the block holds all state.
- `issue_valid` in 1: rename `issue_rd` to `issue_rob_entry`.
- `issue_rd` in 5: destination register being renamed.
- `issue_rob_entry` in `ROB_BIT`: ROB tag for the rename.
- `commit_valid` in 1: write `commit_value` to `commit_rd`.
- `commit_rd` in 5: destination register of the committing instruction.
- `commit_rob_entry` in `ROB_BIT`: tag of the committing entry.
- `commit_value` in 32: committed result.
- `clear_up` in 1: mispredict flush.
- `rs1_id`, `rs2_id` in 5 each: decoder operand register indices.
- `rs1_ready`, `rs2_ready` out 1: operand value is valid this cycle.
- `rs1_value`, `rs2_value` out 32: operand value; 0 when not ready.
- `rs1_rob_entry`, `rs2_rob_entry` out `ROB_BIT`: pending producer tag; 0 when ready.
- `get_rob_entry1`, `get_rob_entry2` out `ROB_BIT`: ROB lookup index, equal to `tag[rsX_id]`.
- `ready1`, `ready2` in 1: ROB lookup result valid.
- `value1`, `value2` in 32: ROB lookup data.

## Operation
- State: `val[0:31]` (32b), `busy[0:31]`, `tag[0:31]` (`ROB_BIT`).
- x0: `val[0]` is always 0 and `busy[0]` is always 0. Issue and commit to x0 are ignored.
- Read (combinational), per port X:
  - `!busy[rsX]`: ready=1, value=`val[rsX]`, rob_entry=0.
  - `busy` and `readyX`: ready=1, value=`valueX`, rob_entry=0.
  - `busy` and `!readyX`: ready=0, value=0, rob_entry=`tag[rsX]`.
- Commit (clocked, `rdy_in`=1, `commit_valid`, rd≠0):
  - `val[rd]` <= `commit_value`.
  - If `busy[rd]` and `tag[rd]==commit_rob_entry`, then `busy[rd]` <= 0. Otherwise busy and tag are unchanged, because a younger rename owns the register.
- Issue (clocked, `rdy_in`=1, `issue_valid`, rd≠0, `!clear_up`): `busy[rd]` <= 1, `tag[rd]` <= `issue_rob_entry`.
- Same cycle, same rd, issue and commit:
  - Value is written.
  - Issue wins busy/tag: busy=1, tag=new entry.
- Flush (`clear_up` and `rdy_in`):
  - All `busy` <= 0.
  - `val` is retained.
  - Same-cycle commit still writes `val`.
  - Same-cycle issue is discarded.
- `rdy_in`=0: no state update. Read outputs still track current state and inputs.

## Timing
- Reset (`rst_in` high at a clock edge): all `val`, `busy` and `tag` cleared. Every read then returns ready=1, value=0, rob_entry=0.
- Reset has priority over flush, commit and issue. Reset mid-operation discards all renames and values.
- Read latency: 0 cycles, purely combinational from `rsX_id`, state and ROB lookup inputs.
- Write latency: commit and issue become visible on reads in the cycle after the edge.
- The ROB keeps a committing entry's prepared bit set during the commit cycle. A read during the commit cycle therefore resolves through `readyX`/`valueX`.

## Configuration
- `REG_BYPASS_EN`:
  - Defined: a read whose register is busy, with `commit_valid`, `commit_rd==rsX_id`, `commit_rob_entry==tag[rsX_id]` and rd≠0, returns ready=1, value=`commit_value` without depending on `readyX`. Bypass has priority over the ROB lookup.
  - Undefined: no commit forwarding; reads use only state and the ROB lookup.
- Registered behaviour is identical either way.

## Test plan
- Reset, then read x5 on both ports -> ready=1, value=0, rob_entry=0. Commit x0=0x1234 -> x0 still reads 0.
- Issue x3→entry 2; next cycle read x3 with `ready1`=0 -> ready=0, rob_entry=2, `get_rob_entry1`=2. Drive `ready1`=1, `value1`=0xDEAD -> ready=1, value=0xDEAD.
- Issue x3→2, then x3→5, then commit x3/entry 2 value 7 -> `val[3]`=7, busy stays 1, tag=5. Commit x3/entry 5 value 9 -> next cycle ready=1, value=9.
- Same-cycle issue x4→6 and commit x4/entry 1 value 0x55 -> next cycle busy=1, tag=6. Later commit entry 6 value 0x66 -> reads 0x66.
- Rename x1, x2 and x7, then `clear_up` with a same-cycle issue x8→3 and commit x9=0xAB -> next cycle all read ready with old values, x8 not busy, x9=0xAB.
- `rdy_in`=0 with issue and commit pulsed -> no change. With `REG_BYPASS_EN`, commit x3/tag-matching value 0x77 while `ready1`=0 -> same-cycle ready=1, value=0x77; without the macro -> ready=0.
